mips_main_ctrl_fsm: RTL and testbench
=====================================

// Module: mips_main_ctrl_fsm
// PURPOSE
//  Multicycle MIPS main control unit. Registers the opcode sequence of each instruction through
//  fetch/decode/execute/memory/writeback states and drives every datapath enable.
//  Produces the 3-bit alu_op consumed by the ALU control decoder downstream. That decoder maps
//  alu_op + funct to the 4-bit ALU function.
//  Memory accesses use a req/ready handshake so variable-latency memory stalls the FSM.
// PARAMETERS
//  TRAP_ILLEGAL  1  1: unknown opcode -> HALT state (sticky); 0: pulse illegal_instr, return to FETCH
// PORTS
//  clk            in   1  system clock, rising edge
//  rst_n          in   1  asynchronous, active-low reset
//  opcode         in   6  instr[31:26] from instruction register (valid from DECODE onward)
//  mem_ready      in   1  memory completes current access this cycle
//  mem_req        out  1  memory access request (FETCH, MEMRD, MEMWR)
//  mem_write      out  1  write strobe, qualifies mem_req in MEMWR
//  iord           out  1  0: address=PC, 1: address=ALUOut
//  ir_write       out  1  load instruction register
//  pc_write       out  1  unconditional PC load
//  branch         out  1  PC load if ALU zero (beq)
//  pc_src         out  2  00 ALU result, 01 ALUOut, 10 jump target
//  alu_src_a      out  1  0 PC, 1 register A
//  alu_src_b      out  2  00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
//  alu_op         out  3  000 add, 001 sub, 010 use funct, 011 and, 100 or, 101 slt
//  reg_write      out  1  register file write
//  reg_dst        out  1  0 rt, 1 rd
//  mem_to_reg     out  1  0 ALUOut, 1 memory data register
//  illegal_instr  out  1  one-cycle pulse on unknown opcode in DECODE
//  halted         out  1  high while in HALT
// BEHAVIOUR
//  - State register resets asynchronously to FETCH. While rst_n=0 every output is 0, alu_op=000.
//  - Outputs are Moore decodes of state, except where noted as qualified by mem_ready. Unlisted outputs are 0.
//  - FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=000, pc_src=00.
//    ir_write and pc_write assert only in the cycle mem_ready=1, then go to DECODE. Otherwise stay.
//  - DECODE: alu_src_a=0, alu_src_b=11, alu_op=000 (branch target precompute).
//    Next state by opcode: lw/sw 100011/101011 -> MEMADR; R 000000 -> REXEC; beq 000100 -> BEQ;
//    j 000010 -> JUMP; addi 001000, andi 001100, ori 001101, slti 001010 -> IEXEC; other -> illegal.
//  - MEMADR: alu_src_a=1, alu_src_b=10, alu_op=000. lw -> MEMRD, sw -> MEMWR.
//  - MEMRD: mem_req=1, iord=1. Wait for mem_ready, then go to MEMWB.
//  - MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1, then go to FETCH.
//  - MEMWR: mem_req=1, mem_write=1, iord=1. Wait for mem_ready, then go to FETCH.
//  - REXEC: alu_src_a=1, alu_src_b=00, alu_op=010, then go to RWB.
//    RWB: reg_write=1, reg_dst=1, mem_to_reg=0, then go to FETCH.
//  - IEXEC: alu_src_a=1, alu_src_b=10; alu_op: addi 000, andi 011, ori 100, slti 101.
//    Then go to IWB. IWB: reg_write=1, reg_dst=0, mem_to_reg=0, then go to FETCH.
//  - BEQ: alu_src_a=1, alu_src_b=00, alu_op=001, branch=1, pc_src=01, then go to FETCH.
//  - JUMP: pc_write=1, pc_src=10, then go to FETCH.
//  - Illegal opcode in DECODE: illegal_instr=1 for that cycle.
//    TRAP_ILLEGAL=1 -> HALT, where halted=1 and all enables are 0 until reset. TRAP_ILLEGAL=0 -> FETCH.
//  - Opcode is sampled in DECODE and registered for the MEMADR and IEXEC branch selections.
//    IR changes after DECODE do not alter the path.
//  - mem_ready outside FETCH/MEMRD/MEMWR is ignored.
//  - mem_ready held low stalls indefinitely with all outputs stable.
//  - Reset asserted mid-instruction: outputs go to 0 immediately, and the FSM restarts in FETCH after release.
//  - Latency with mem_ready=1 every request:
//    lw 5 cycles; sw, R, addi-class 4 cycles; beq, j 3 cycles.
// STRUCTURE
//  - Package mips_ctrl_pkg: opcode localparams, alu_op codes (ALUOP_ADD..ALUOP_SLT), state enum/encoding.
//    The ALU control decoder imports the same alu_op codes.
//  - One sub-module, mips_ctrl_outdec: purely combinational state(+opcode_q, mem_ready) -> outputs.
//    The top holds the state register, opcode_q and next-state logic.
// TESTING
//  - Reset: rst_n=0 mid-MEMRD -> all outputs 0 the same cycle; after release FETCH with mem_req=1, alu_src_b=01.
//  - R-type add (opcode 0, mem_ready=1):
//    REXEC alu_op=010, RWB reg_write=1 reg_dst=1, back in FETCH on cycle 5.
//  - lw with mem_ready low for 3 cycles in MEMRD:
//    mem_req=1 iord=1 held, MEMWB reg_write=1 mem_to_reg=1, 8 cycles total.
//  - ori 001101 -> IEXEC alu_op=100 alu_src_b=10. slti 001010 -> alu_op=101. andi -> 011. addi -> 000.
//  - beq 000100 -> BEQ alu_op=001 branch=1 pc_src=01; j 000010 -> pc_write=1 pc_src=10; both 3 cycles.
//  - Opcode 111111: TRAP_ILLEGAL=1 -> illegal_instr 1-cycle pulse, halted=1 sticky, no further mem_req;
//    TRAP_ILLEGAL=0 -> pulse, then FETCH.

Source files
------------

// File: rtl/mips_main_ctrl_fsm_pkg.sv
// Shared definitions for the multicycle MIPS main control: opcodes, alu_op codes,
// FSM state encoding and the bundled control-word type.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_FUNCT = 3'b010;
    localparam logic [2:0] ALUOP_AND   = 3'b011;
    localparam logic [2:0] ALUOP_OR    = 3'b100;
    localparam logic [2:0] ALUOP_SLT   = 3'b101;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_REXEC  = 4'd6,
        S_RWB    = 4'd7,
        S_IEXEC  = 4'd8,
        S_IWB    = 4'd9,
        S_BEQ    = 4'd10,
        S_JUMP   = 4'd11,
        S_HALT   = 4'd12
    } state_t;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic       branch;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       illegal_instr;
        logic       halted;
    } ctrl_t;

    function automatic logic is_legal(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_SLTI,
            OP_ANDI, OP_ORI, OP_LW, OP_SW: return 1'b1;
            default:                       return 1'b0;
        endcase
    endfunction

    // Immediate-class ALU operation; anything else falls back to add (addi).
    function automatic logic [2:0] iexec_aluop(input logic [5:0] op);
        case (op)
            OP_ANDI: return ALUOP_AND;
            OP_ORI:  return ALUOP_OR;
            OP_SLTI: return ALUOP_SLT;
            default: return ALUOP_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mips_main_ctrl_fsm_outdec.sv
// Combinational control-word decode from FSM state; only FETCH looks at mem_ready
// and only DECODE looks at the live opcode.
module mips_ctrl_outdec
    import mips_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] opcode,
    input  logic [5:0] opcode_q,
    input  logic       mem_ready,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_req   = 1'b1;
                ctrl.alu_src_b = 2'b01;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b     = 2'b11;
                ctrl.alu_op        = ALUOP_ADD;
                ctrl.illegal_instr = !is_legal(opcode);
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b10;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl.mem_req = 1'b1;
                ctrl.iord    = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_req   = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            S_REXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b00;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_RWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_IEXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b10;
                ctrl.alu_op    = iexec_aluop(opcode_q);
            end
            S_IWB: begin
                ctrl.reg_write = 1'b1;
            end
            S_BEQ: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b00;
                ctrl.alu_op    = ALUOP_SUB;
                ctrl.branch    = 1'b1;
                ctrl.pc_src    = 2'b01;
            end
            S_JUMP: begin
                ctrl.pc_write = 1'b1;
                ctrl.pc_src   = 2'b10;
            end
            S_HALT: begin
                ctrl.halted = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mips_main_ctrl_fsm.sv
// Multicycle MIPS main control FSM: state register, latched opcode and next-state logic,
// with the output decode delegated to mips_ctrl_outdec.
module mips_main_ctrl_fsm
    import mips_ctrl_pkg::*;
#(
    parameter bit TRAP_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic       branch,
    output logic [1:0] pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       illegal_instr,
    output logic       halted
);

    state_t     state_reg, state_next;
    logic [5:0] opcode_reg;
    ctrl_t      dec_ctrl, ctrl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= S_FETCH;
            opcode_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == S_DECODE)
                opcode_reg <= opcode;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_FETCH:  if (mem_ready) state_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:                       state_next = S_MEMADR;
                    OP_RTYPE:                           state_next = S_REXEC;
                    OP_BEQ:                             state_next = S_BEQ;
                    OP_J:                               state_next = S_JUMP;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI:  state_next = S_IEXEC;
                    default: state_next = TRAP_ILLEGAL ? S_HALT : S_FETCH;
                endcase
            end
            // Load/store choice uses the opcode captured in DECODE, not the live IR.
            S_MEMADR: state_next = (opcode_reg == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (mem_ready) state_next = S_MEMWB;
            S_MEMWB:  state_next = S_FETCH;
            S_MEMWR:  if (mem_ready) state_next = S_FETCH;
            S_REXEC:  state_next = S_RWB;
            S_RWB:    state_next = S_FETCH;
            S_IEXEC:  state_next = S_IWB;
            S_IWB:    state_next = S_FETCH;
            S_BEQ:    state_next = S_FETCH;
            S_JUMP:   state_next = S_FETCH;
            S_HALT:   state_next = S_HALT;
            default:  state_next = S_FETCH;
        endcase
    end

    mips_ctrl_outdec u_outdec (
        .state     (state_reg),
        .opcode    (opcode),
        .opcode_q  (opcode_reg),
        .mem_ready (mem_ready),
        .ctrl      (dec_ctrl)
    );

    // Every output is forced low for as long as reset is held, not just after the edge.
    assign ctrl = rst_n ? dec_ctrl : '0;

    assign mem_req       = ctrl.mem_req;
    assign mem_write     = ctrl.mem_write;
    assign iord          = ctrl.iord;
    assign ir_write      = ctrl.ir_write;
    assign pc_write      = ctrl.pc_write;
    assign branch        = ctrl.branch;
    assign pc_src        = ctrl.pc_src;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
    assign reg_write     = ctrl.reg_write;
    assign reg_dst       = ctrl.reg_dst;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign illegal_instr = ctrl.illegal_instr;
    assign halted        = ctrl.halted;

endmodule

// File: tb/tb_mips_main_ctrl_fsm.sv
// Directed scoreboard bench for mips_main_ctrl_fsm: one instance per TRAP_ILLEGAL setting,
// both fed the same stimulus, each checked against its own expected control word.
module tb_mips_main_ctrl_fsm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;

    logic       mreq0, mwr0, iord0, irw0, pcw0, br0, asa0, rw0, rd0, m2r0, ill0, hlt0;
    logic [1:0] psrc0, asb0;
    logic [2:0] aop0;
    logic       mreq1, mwr1, iord1, irw1, pcw1, br1, asa1, rw1, rd1, m2r1, ill1, hlt1;
    logic [1:0] psrc1, asb1;
    logic [2:0] aop1;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    mips_main_ctrl_fsm #(.TRAP_ILLEGAL(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .mem_req(mreq0), .mem_write(mwr0), .iord(iord0), .ir_write(irw0),
        .pc_write(pcw0), .branch(br0), .pc_src(psrc0), .alu_src_a(asa0),
        .alu_src_b(asb0), .alu_op(aop0), .reg_write(rw0), .reg_dst(rd0),
        .mem_to_reg(m2r0), .illegal_instr(ill0), .halted(hlt0)
    );

    mips_main_ctrl_fsm #(.TRAP_ILLEGAL(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .mem_req(mreq1), .mem_write(mwr1), .iord(iord1), .ir_write(irw1),
        .pc_write(pcw1), .branch(br1), .pc_src(psrc1), .alu_src_a(asa1),
        .alu_src_b(asb1), .alu_op(aop1), .reg_write(rw1), .reg_dst(rd1),
        .mem_to_reg(m2r1), .illegal_instr(ill1), .halted(hlt1)
    );

    wire [18:0] obs0 = {mreq0, mwr0, iord0, irw0, pcw0, br0, psrc0, asa0, asb0, aop0,
                        rw0, rd0, m2r0, ill0, hlt0};
    wire [18:0] obs1 = {mreq1, mwr1, iord1, irw1, pcw1, br1, psrc1, asa1, asb1, aop1,
                        rw1, rd1, m2r1, ill1, hlt1};

    function automatic logic [18:0] mk(
        input logic mreq, mwr, io, irw, pcw, br, input logic [1:0] psrc,
        input logic sa, input logic [1:0] sb, input logic [2:0] aop,
        input logic rw, rd, m2r, ill, hlt);
        return {mreq, mwr, io, irw, pcw, br, psrc, sa, sb, aop, rw, rd, m2r, ill, hlt};
    endfunction

    typedef struct {
        string      tag;
        logic       rdy;
        logic [5:0] op;
    } stim_t;

    typedef struct {
        logic [18:0] e0;
        logic [18:0] e1;
    } exp_t;

    stim_t stim_q[$];
    exp_t  exp_q[$];

    logic [18:0] E_ZERO, F_WAIT, F_RDY, DEC, DEC_ILL, MADR, MRD, MWB, MWR;
    logic [18:0] REX, RWB, IWB, BEQ, JMP, HALT, IEX_ADD, IEX_AND, IEX_OR, IEX_SLT;

    task automatic check(input string tag, input logic [18:0] obs, input logic [18:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s observed=%05h expected=%05h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic rdy, input logic [5:0] op,
                        input logic [18:0] e0, input logic [18:0] e1);
        stim_t s;
        exp_t  e;
        s.tag = tag; s.rdy = rdy; s.op = op;
        e.e0 = e0;   e.e1 = e1;
        stim_q.push_back(s);
        exp_q.push_back(e);
    endtask

    // Same expectation for both instances (legal instruction streams).
    task automatic push2(input string tag, input logic rdy, input logic [5:0] op,
                         input logic [18:0] e);
        push(tag, rdy, op, e, e);
    endtask

    task automatic run_queue();
        stim_t s;
        exp_t  e;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            @(negedge clk);
            mem_ready = s.rdy;
            opcode    = s.op;
            #1;
            e = exp_q.pop_front();
            check({s.tag, "/trap0"}, obs0, e.e0);
            check({s.tag, "/trap1"}, obs1, e.e1);
            $display("step %-12s rdy=%0b op=%06b dut0=%05h dut1=%05h", s.tag, s.rdy, s.op, obs0, obs1);
        end
    endtask

    task automatic push_itype(input string tag, input logic [5:0] op, input logic [5:0] exec_op,
                              input logic [18:0] iex);
        push2({tag, "_f"},  1'b1, op, F_RDY);
        push2({tag, "_d"},  1'b0, op, DEC);
        push2({tag, "_ex"}, 1'b0, exec_op, iex);
        push2({tag, "_wb"}, 1'b0, exec_op, IWB);
    endtask

    initial begin
        //          mreq mwr io irw pcw br psrc sa sb     aop    rw rd m2r ill hlt
        E_ZERO  = mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 0, 0, 0, 0);
        F_WAIT  = mk(1, 0, 0, 0, 0, 0, 2'b00, 0, 2'b01, 3'b000, 0, 0, 0, 0, 0);
        F_RDY   = mk(1, 0, 0, 1, 1, 0, 2'b00, 0, 2'b01, 3'b000, 0, 0, 0, 0, 0);
        DEC     = mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b11, 3'b000, 0, 0, 0, 0, 0);
        DEC_ILL = mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b11, 3'b000, 0, 0, 0, 1, 0);
        MADR    = mk(0, 0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 3'b000, 0, 0, 0, 0, 0);
        MRD     = mk(1, 0, 1, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 0, 0, 0, 0);
        MWB     = mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 1, 0, 1, 0, 0);
        MWR     = mk(1, 1, 1, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 0, 0, 0, 0);
        REX     = mk(0, 0, 0, 0, 0, 0, 2'b00, 1, 2'b00, 3'b010, 0, 0, 0, 0, 0);
        RWB     = mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 1, 1, 0, 0, 0);
        IWB     = mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 1, 0, 0, 0, 0);
        BEQ     = mk(0, 0, 0, 0, 0, 1, 2'b01, 1, 2'b00, 3'b001, 0, 0, 0, 0, 0);
        JMP     = mk(0, 0, 0, 0, 1, 0, 2'b10, 0, 2'b00, 3'b000, 0, 0, 0, 0, 0);
        HALT    = mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 0, 0, 0, 1);
        IEX_ADD = mk(0, 0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 3'b000, 0, 0, 0, 0, 0);
        IEX_AND = mk(0, 0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 3'b011, 0, 0, 0, 0, 0);
        IEX_OR  = mk(0, 0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 3'b100, 0, 0, 0, 0, 0);
        IEX_SLT = mk(0, 0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 3'b101, 0, 0, 0, 0, 0);

        rst_n     = 1'b0;
        opcode    = 6'b000000;
        mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("reset_hold/trap0", obs0, E_ZERO);
        check("reset_hold/trap1", obs1, E_ZERO);
        @(negedge clk);
        rst_n     = 1'b1;
        mem_ready = 1'b0;
        #1;
        check("reset_rel/trap0", obs0, F_WAIT);
        check("reset_rel/trap1", obs1, F_WAIT);

        // lw interrupted by reset while MEMRD is waiting.
        push2("lwr_f",  1'b1, 6'b100011, F_RDY);
        push2("lwr_d",  1'b0, 6'b100011, DEC);
        push2("lwr_ma", 1'b0, 6'b100011, MADR);
        push2("lwr_mr", 1'b0, 6'b100011, MRD);
        run_queue();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid/trap0", obs0, E_ZERO);
        check("rst_mid/trap1", obs1, E_ZERO);
        @(negedge clk);
        #1;
        check("rst_edge/trap0", obs0, E_ZERO);
        check("rst_edge/trap1", obs1, E_ZERO);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_restart/trap0", obs0, F_WAIT);
        check("rst_restart/trap1", obs1, F_WAIT);

        // R-type; mem_ready=1 in DECODE must be ignored.
        push2("r_f",   1'b1, 6'b000000, F_RDY);
        push2("r_d",   1'b1, 6'b000000, DEC);
        push2("r_ex",  1'b0, 6'b000000, REX);
        push2("r_wb",  1'b0, 6'b000000, RWB);

        // lw with three stalled MEMRD cycles: 8 cycles total.
        push2("lw_f",   1'b1, 6'b100011, F_RDY);
        push2("lw_d",   1'b0, 6'b100011, DEC);
        push2("lw_ma",  1'b0, 6'b100011, MADR);
        push2("lw_st1", 1'b0, 6'b100011, MRD);
        push2("lw_st2", 1'b0, 6'b100011, MRD);
        push2("lw_st3", 1'b0, 6'b100011, MRD);
        push2("lw_mr",  1'b1, 6'b100011, MRD);
        push2("lw_wb",  1'b0, 6'b100011, MWB);

        // sw; IR changed to lw after DECODE must not redirect to MEMRD.
        push2("sw_f",  1'b1, 6'b101011, F_RDY);
        push2("sw_d",  1'b0, 6'b101011, DEC);
        push2("sw_ma", 1'b0, 6'b100011, MADR);
        push2("sw_mw", 1'b1, 6'b100011, MWR);

        push_itype("ori",  6'b001101, 6'b000000, IEX_OR);
        push_itype("slti", 6'b001010, 6'b001010, IEX_SLT);
        push_itype("andi", 6'b001100, 6'b001100, IEX_AND);
        push_itype("addi", 6'b001000, 6'b001101, IEX_ADD);

        push2("beq_f",  1'b1, 6'b000100, F_RDY);
        push2("beq_d",  1'b0, 6'b000100, DEC);
        push2("beq_ex", 1'b0, 6'b000100, BEQ);
        push2("j_f",    1'b1, 6'b000010, F_RDY);
        push2("j_d",    1'b0, 6'b000010, DEC);
        push2("j_ex",   1'b0, 6'b000010, JMP);
        push2("j_done", 1'b0, 6'b000010, F_WAIT);
        run_queue();

        // Illegal opcode: trap0 returns to FETCH, trap1 halts for good.
        push2("ill_f",  1'b1, 6'b111111, F_RDY);
        push2("ill_d",  1'b0, 6'b111111, DEC_ILL);
        push("ill_n1",  1'b0, 6'b000000, F_WAIT, HALT);
        push("ill_n2",  1'b1, 6'b000000, F_RDY,  HALT);
        push("ill_n3",  1'b1, 6'b000000, DEC,    HALT);
        push("ill_n4",  1'b0, 6'b000000, REX,    HALT);
        run_queue();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
